// File: rtl/brent_kung_16bit_if.sv
// Operand/result bundle for the 16-bit Brent-Kung adder.
// Operands a, b, cin go into the adder; registered s, cout come back out.
interface brent_kung_16bit_if;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] s;
  logic        cout;

  modport master (output a, b, cin, input s, cout);
  modport slave  (input a, b, cin, output s, cout);
endinterface

// File: rtl/brent_kung_16bit.sv
// 16-bit adder with a Brent-Kung parallel-prefix carry network.
// The sum and carry-out are registered, giving a latency of one cycle.
module brent_kung_16bit (
  input logic               clk,
  input logic               rst,
  brent_kung_16bit_if.slave bus
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] gl [0:7];
  logic [15:0] pl [0:3];
  logic [16:0] c;
  logic [15:0] sum;

  assign g = bus.a & bus.b;
  assign p = bus.a ^ bus.b;

  always_comb begin
    for (int unsigned l = 0; l < 8; l++) gl[l] = '0;
    for (int unsigned l = 0; l < 4; l++) pl[l] = '0;

    // Position 0 absorbs cin (G[-1]), so every later span ending at bit 0
    // already covers the carry-in.
    gl[0]    = g;
    gl[0][0] = g[0] | (p[0] & bus.cin);
    pl[0]    = p;

    // Up-sweep, levels 1-3: black cells at spans 2, 4 and 8.
    for (int unsigned l = 1; l < 4; l++) begin
      gl[l] = gl[l-1];
      pl[l] = pl[l-1];
      for (int unsigned i = 0; i < 16; i++) begin
        if (((i + 1) % (1 << l)) == 0) begin
          gl[l][i] = gl[l-1][i] | (pl[l-1][i] & gl[l-1][i - (1 << (l-1))]);
          pl[l][i] = pl[l-1][i] & pl[l-1][i - (1 << (l-1))];
        end
      end
    end

    // Level 4 (span 16) and everything after it need G only.
    gl[4]     = gl[3];
    gl[4][15] = gl[3][15] | (pl[3][15] & gl[3][7]);

    // Down-sweep: 11 from 7.
    gl[5]     = gl[4];
    gl[5][11] = gl[4][11] | (pl[3][11] & gl[4][7]);

    // Down-sweep: 5, 9, 13 from 3, 7, 11.
    gl[6] = gl[5];
    for (int unsigned i = 5; i < 16; i += 4) begin
      gl[6][i] = gl[5][i] | (pl[2][i] & gl[5][i-2]);
    end

    // Down-sweep: even positions from their odd neighbour below.
    gl[7] = gl[6];
    for (int unsigned i = 2; i < 16; i += 2) begin
      gl[7][i] = gl[6][i] | (pl[0][i] & gl[6][i-1]);
    end
  end

  assign c   = {gl[7], bus.cin};
  assign sum = p ^ c[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s    <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.s    <= sum;
      bus.cout <= c[16];
    end
  end

endmodule

// File: tb/tb_brent_kung_16bit.sv
// Scoreboard bench for brent_kung_16bit: the driver queues the expected
// {cout, s} for every cycle, and a monitor checks each registered result.
module tb_brent_kung_16bit;

  logic clk;
  logic rst;
  brent_kung_16bit_if bus ();

  brent_kung_16bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;

  // Inputs are driven while clk is low. The result of this cycle shows up
  // just after the next rising edge.
  task automatic op(input logic r, input logic [15:0] a, input logic [15:0] b,
                    input logic ci, input logic [16:0] exp, input string name);
    item_t it;
    rst    = r;
    bus.a   = a;
    bus.b   = b;
    bus.cin = ci;
    it.exp  = exp;
    it.name = name;
    q.push_back(it);
    @(negedge clk);
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        it = q.pop_front();
        checks++;
        if ({bus.cout, bus.s} !== it.exp) begin
          errors++;
          $display("FAIL %s: got cout=%b s=%h, expected cout=%b s=%h",
                   it.name, bus.cout, bus.s, it.exp[16], it.exp[15:0]);
        end
      end
    end
  end

  initial begin : driver
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    int          wait_cycles;

    op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h00000, "reset0");
    op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h00000, "reset1");
    op(1'b0, 16'h0000, 16'h0000, 1'b0, 17'h00000, "zero");
    op(1'b0, 16'h000F, 16'h0001, 1'b0, 17'h00010, "small");
    op(1'b0, 16'hFE01, 16'h001A, 1'b0, 17'h0FE1B, "partial1");
    op(1'b0, 16'hFF24, 16'h001A, 1'b0, 17'h0FF3E, "partial2");
    op(1'b0, 16'h1234, 16'h5678, 1'b0, 17'h068AC, "mixed");
    op(1'b0, 16'hABCD, 16'hDCBA, 1'b0, 17'h18887, "overflow");
    op(1'b0, 16'hFFFF, 16'h0000, 1'b1, 17'h10000, "fullprop");
    op(1'b0, 16'h7FFF, 16'h0000, 1'b1, 17'h08000, "prop15");
    op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, "maxall");
    op(1'b0, 16'h8000, 16'h8000, 1'b0, 17'h10000, "msbonly");
    op(1'b0, 16'hAAAA, 16'h5555, 1'b1, 17'h10000, "altprop_c");
    op(1'b0, 16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF, "altprop");
    op(1'b0, 16'h0001, 16'h0001, 1'b0, 17'h00002, "pre_rst");
    op(1'b1, 16'h1234, 16'h1111, 1'b1, 17'h00000, "mid_rst");
    op(1'b0, 16'h0F0F, 16'hF0F0, 1'b1, 17'h10000, "post_rst");

    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(1, 0));
      op(1'b0, ra, rb, rc, 17'(ra) + 17'(rb) + 17'(rc), "random");
    end

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      #2;
      wait_cycles++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/brent_kung_16bit.md
# brent_kung_16bit

16-bit binary adder with carry-in and carry-out. The carry network is a Brent-Kung parallel-prefix tree. It serves as the fast final-stage adder of the MAC datapath. The sum and carry-out are captured in an output register, so downstream MAC stages see a clean, cycle-aligned result.

## Interface
- No parameters; width fixed at 16.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  16  addend A, unsigned.
- b  input  16  addend B, unsigned.
- cin  input  1  carry into bit 0.
- s  output  16  registered sum bits [15:0].
- cout  output  1  registered carry out of bit 15.

## Operation
- Combinational core computes {cout, s} = a + b + cin, as a 17-bit exact result with no overflow loss.
- Bit-level generate/propagate:
  - g[i] = a[i] & b[i]
  - p[i] = a[i] ^ b[i]
- cin is folded in as the prefix of position −1: G[-1] = cin.
- Black-cell operator: (G,P) ∘ (G',P') = (G | P&G', P&P').
- Gray cells (G only) are used wherever P is no longer needed.
- Up-sweep (4 levels):
  - Spans 2, 4, 8, 16 formed at bit indices 1,3,5,…,15; then 3,7,11,15; then 7,15; then 15.
- Down-sweep (3 levels):
  - Fills 11 (from 7).
  - Fills 5, 9, 13 (from 3, 7, 11).
  - Fills even indices 2,4,…,14 (from index−1).
- Total prefix depth is 7 cell levels. No ripple chain may exceed one cell between levels.
- Carries and outputs:
  - c[0] = cin; c[i+1] = G[i:−1].
  - s[i] = p[i] ^ c[i].
  - cout = c[16].
- Structural Brent-Kung implementation is required. A behavioural "+" is not accepted for the core; results must still be bit-exact to a + b + cin.
- Inputs are not registered. Input values present at a rising clk edge determine the output after that edge.

## Timing
- Latency: 1 cycle. Values of a, b, cin sampled at rising edge k appear on s/cout after edge k and hold until edge k+1.
- Throughput: one new addition per cycle. There is no handshake and no valid signal; every cycle is an operation.
- Reset:
  - When rst=1 at a rising edge, s ← 16'h0000 and cout ← 0, regardless of a/b/cin.
  - Reset takes priority over the computed result.
  - The first result after reset deasserts is from the inputs sampled at the first edge with rst=0.
- Before the first reset, output values are undefined. Benches must apply reset first.
- Critical path: input → 7 prefix levels → XOR → register D. It must close at the MAC clock.

## Test plan
- Reset and identities:
  - Assert rst for 2 cycles with a=FFFF, b=FFFF, cin=1 → s=0000, cout=0 throughout.
  - Release reset; a=0000, b=0000, cin=0 → next cycle s=0000, cout=0.
- Small and partial-carry cases, one cycle later each:
  - a=000F, b=0001, cin=0 → s=0010, cout=0.
  - a=FE01, b=001A → s=FE1B, cout=0.
  - a=FF24, b=001A → s=FF3E, cout=0.
- Mixed and overflow cases:
  - a=1234, b=5678, cin=0 → s=68AC, cout=0.
  - a=ABCD, b=DCBA, cin=0 → s=8887, cout=1.
- Full-length carry propagation:
  - a=FFFF, b=0000, cin=1 → s=0000, cout=1.
  - a=7FFF, b=0000, cin=1 → s=8000, cout=0.
- Reset mid-stream:
  - Apply back-to-back operands every cycle, then assert rst for one edge → that cycle's output is 0000/0.
  - The next operand's result appears one cycle after rst drops.
- Random regression: ≥10k random a, b, cin, pipelined every cycle → {cout, s} equals a + b + cin from the previous edge.
